serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial 8-bit unsigned subtractor for the ALU datapath; computes a - b.
- It is the inverse operation of the ripple adder.
- One bit is processed per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Result is 9 bits {borrow, difference} and has the same width and bus format as the adder result. It is driven onto the shared ALU result bus through an EN-controlled tri-state.

Parameters:
- WIDTH, 8, operand width in bits; the result is WIDTH+1 bits.
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; operands are sampled when start=1 in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- EN  input  1  bus output enable; 1 drives d, 0 puts d at high impedance.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when a new result is valid.
- d  output  WIDTH+1  result bus: d[WIDTH] = final borrow, d[WIDTH-1:0] = difference.

Behaviour:
- Interface (decided): one clock, clk. Reset rst_n is asynchronous and active-low. All state is updated on the rising edge of clk.
- Reset values:
  - FSM = IDLE, busy=0, done=0.
  - Internal result register = 0, so d = 0 when EN=1.
  - Operand shift registers, borrow flip-flop and bit counter are cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: load sa<=a, sb<=b, borrow<=0, cnt<=0, then go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, on each edge:
  - diff = sa[0]^sb[0]^borrow.
  - borrow <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow).
  - The partial-result shift register shifts right, with diff inserted at bit WIDTH-1.
  - sa and sb shift right; cnt increments.
  - On the edge where cnt==WIDTH-1 (the last bit), go to DONE.
- DONE (one cycle):
  - Result register <= {borrow, partial}.
  - done=1 for exactly this cycle; then return to IDLE unconditionally.
- busy = 1 in SHIFT and DONE, 0 in IDLE.
- Latency: with start sampled at edge k, done is high during the cycle after edge k+WIDTH+1, and d shows the new value from that same edge. With WIDTH=8 this is 9 cycles from start to done.
- start while busy=1: ignored. The running operation is not disturbed and nothing is queued.
- a and b may change freely after the sampling edge; the result is unaffected.
- Back-to-back operation: start may be asserted in the cycle after done (FSM is in IDLE).
- d holds the last completed result until the next DONE or a reset. A partial result is never visible on d.
- EN is purely combinational on d:
  - EN=1: d = result register.
  - EN=0: d = all Z.
  - EN does not affect the FSM, busy or done.
- Reset asserted mid-operation: immediate return to IDLE, d = 0, busy=0, done=0, no done pulse.
- Arithmetic: unsigned modulo 2**WIDTH.
  - d[WIDTH]=1 exactly when a < b.
  - a == b gives d = 0.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit); reset value 0.
  - ovf is updated in DONE to signed two's-complement overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the sampled operand MSBs.
  - ovf holds its value with d.
  - ovf is not tri-stated.
- Not defined: there is no ovf port and no associated logic; all other behaviour is identical.

Test Plan:
- Reset then a=0x50, b=0x20, start pulse, EN=1 -> done 9 cycles later, d=0x030, busy low after done.
- a=0x20, b=0x50 -> d=0x1D0 (borrow=1). a=0x00, b=0x01 -> d=0x1FF. a=b=0xA5 -> d=0x000.
- start again 3 cycles into an op with a=0xFF, b=0x00 -> ignored: single done, first result intact, no second done.
- EN=0 across a full op -> d all Z throughout; EN=1 afterwards -> d shows the completed result.
- rst_n low at SHIFT cycle 4 -> busy=0, done never pulses, d=0x000; a new start then completes normally.
- With SERIAL_SUB_OVF_EN: 0x80-0x01 -> d=0x07F, ovf=1; 0x7F-0xFF -> d=0x180, ovf=1; 0x10-0x01 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flip-flop. The result is
// presented as {borrow, difference}, the same width and format as the ripple
// adder result, and is driven onto the shared ALU result bus through an
// EN-controlled tri-state.
//
// Parameters
//   WIDTH  operand width in bits (result is WIDTH+1 bits)
//   CNT_W  bit-counter width, 2**CNT_W must exceed WIDTH
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request; operands sampled when start=1 in IDLE
//   a      in   minuend   [WIDTH-1:0]
//   b      in   subtrahend [WIDTH-1:0]
//   EN     in   bus output enable (1 drives d, 0 releases d to Z)
//   busy   out  high while an operation is in progress (SHIFT and DONE)
//   done   out  one-cycle pulse when a new result is valid on d
//   d      out  result bus [WIDTH:0]: d[WIDTH]=borrow, d[WIDTH-1:0]=difference
//   ovf    out  (only with SERIAL_SUB_OVF_EN) signed two's-complement overflow
//
// Optional feature
//   Define SERIAL_SUB_OVF_EN to add the ovf output. Without it there is no
//   ovf port and no overflow logic.
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             EN,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   d
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // The counter must be able to reach WIDTH-1.
    if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt_w
        $error("serial_subtractor: CNT_W too small for WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_reg,   state_next;
    logic [WIDTH-1:0]   sa_reg,      sa_next;
    logic [WIDTH-1:0]   sb_reg,      sb_next;
    logic               borrow_reg,  borrow_next;
    logic [CNT_W-1:0]   cnt_reg,     cnt_next;
    logic [WIDTH-1:0]   partial_reg, partial_next;
    logic [WIDTH:0]     result_reg,  result_next;
    logic               done_reg,    done_next;

    // Full-subtractor cell operating on the current LSBs.
    logic diff_bit;
    logic borrow_out;

    always_comb begin
        diff_bit   = sa_reg[0] ^ sb_reg[0] ^ borrow_reg;
        borrow_out = (~sa_reg[0] & sb_reg[0]) |
                     (~(sa_reg[0] ^ sb_reg[0]) & borrow_reg);
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits captured at the sampling edge, so later changes on
    // a/b cannot disturb the overflow decision.
    logic a_msb_reg, a_msb_next;
    logic b_msb_reg, b_msb_next;
    logic ovf_reg,   ovf_next;
`endif

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        sa_next      = sa_reg;
        sb_next      = sb_reg;
        borrow_next  = borrow_reg;
        cnt_next     = cnt_reg;
        partial_next = partial_reg;
        result_next  = result_reg;
        done_next    = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_next   = a_msb_reg;
        b_msb_next   = b_msb_reg;
        ovf_next     = ovf_reg;
`endif

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    sa_next     = a;
                    sb_next     = b;
                    borrow_next = 1'b0;
                    cnt_next    = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_next  = a[WIDTH-1];
                    b_msb_next  = b[WIDTH-1];
`endif
                    state_next  = SHIFT;
                end
            end

            SHIFT: begin
                // New difference bit enters at the top; after WIDTH shifts
                // the first (LSB) difference bit has reached bit 0.
                partial_next = {diff_bit, partial_reg[WIDTH-1:1]};
                borrow_next  = borrow_out;
                sa_next      = {1'b0, sa_reg[WIDTH-1:1]};
                sb_next      = {1'b0, sb_reg[WIDTH-1:1]};
                cnt_next     = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_BIT) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                // Only here does the visible result change, so a partial
                // result never reaches the bus. done is registered alongside
                // so the pulse lines up with the new value on d.
                result_next = {borrow_reg, partial_reg};
                done_next   = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                ovf_next    = (a_msb_reg != b_msb_reg) &&
                              (partial_reg[WIDTH-1] != a_msb_reg);
`endif
                state_next  = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            sa_reg      <= '0;
            sb_reg      <= '0;
            borrow_reg  <= 1'b0;
            cnt_reg     <= '0;
            partial_reg <= '0;
            result_reg  <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sa_reg      <= sa_next;
            sb_reg      <= sb_next;
            borrow_reg  <= borrow_next;
            cnt_reg     <= cnt_next;
            partial_reg <= partial_next;
            result_reg  <= result_next;
            done_reg    <= done_next;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            a_msb_reg <= a_msb_next;
            b_msb_reg <= b_msb_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Not tri-stated: ovf is a private status line, not part of the bus.
    assign ovf = ovf_reg;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy = (state_reg != IDLE);
    assign done = done_reg;

    // EN only gates the bus driver; it has no effect on the FSM.
    assign d = EN ? result_reg : {(WIDTH + 1){1'bz}};

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed, table-driven bench for serial_subtractor (WIDTH=8). A table of
// {a, b, expected d, expected ovf} records is applied in a loop; hand-written
// sequences cover back-to-back operation, start while busy, bus release with
// EN=0, and reset in the middle of an operation.
//
// The bench owns a second driver on the d net. While EN=0 it drives known
// patterns; reading those patterns back unchanged shows the DUT has released
// the bus (a DUT still driving a nonzero value would corrupt at least one of
// two complementary patterns).
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       EN;
    logic       busy;
    logic       done;
    tri   [8:0] d;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    logic       drv_en;
    logic [8:0] drv_val;
    assign d = drv_en ? drv_val : 9'bz;

    int n_vec;
    int n_err;

    serial_subtractor #(
        .WIDTH(8),
        .CNT_W(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .EN   (EN),
        .busy (busy),
        .done (done),
        .d    (d)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [8:0] exp_d;
        logic       exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Called at a negedge in IDLE: presents operands with start=1 so the
    // next rising edge samples them.
    task automatic issue(input logic [7:0] na, input logic [7:0] nb);
        a     = na;
        b     = nb;
        start = 1'b1;
    endtask

    // Waits for done (bounded). lat counts rising edges from the sampling
    // edge to the edge that raised done; -1 on timeout. Operands are scrambled
    // right after sampling to show the result does not depend on them.
    task automatic wait_done(output int lat, output logic [8:0] got_d,
                             output logic got_ovf, output logic busy_pre);
        lat      = -1;
        got_d    = '0;
        got_ovf  = 1'b0;
        busy_pre = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                a     = ~a;
                b     = ~b;
            end
            if (done) begin
                lat   = i - 1;
                got_d = d;
`ifdef SERIAL_SUB_OVF_EN
                got_ovf = ovf;
`endif
                break;
            end
            busy_pre = busy;
        end
    endtask

    vec_t vecs[9];

    initial begin
        int         lat;
        logic [8:0] got_d;
        logic       got_ovf;
        logic       busy_pre;
        int         ndone;
        int         bad;
        logic [8:0] dval;

        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        EN      = 1'b1;
        drv_en  = 1'b0;
        drv_val = '0;

        vecs[0] = '{8'h50, 8'h20, 9'h030, 1'b0};
        vecs[1] = '{8'h20, 8'h50, 9'h1D0, 1'b0};
        vecs[2] = '{8'h00, 8'h01, 9'h1FF, 1'b0};
        vecs[3] = '{8'hA5, 8'hA5, 9'h000, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 9'h07F, 1'b1};
        vecs[5] = '{8'h7F, 8'hFF, 9'h180, 1'b1};
        vecs[6] = '{8'h10, 8'h01, 9'h00F, 1'b0};
        vecs[7] = '{8'hFF, 8'h00, 9'h0FF, 1'b0};
        vecs[8] = '{8'h00, 8'hFF, 9'h101, 1'b0};

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_d", 32'(d), 32'h000);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // ---------------- table-driven vectors ----------------
        for (int v = 0; v < 9; v++) begin
            issue(vecs[v].va, vecs[v].vb);
            wait_done(lat, got_d, got_ovf, busy_pre);
            $display("op %0d: a=0x%02h b=0x%02h d=0x%03h latency=%0d",
                     v, vecs[v].va, vecs[v].vb, got_d, lat);
            check("vec_d", 32'(got_d), 32'(vecs[v].exp_d));
            check("vec_latency", 32'(lat), 32'd9);
            check("vec_busy_in_done_state", 32'(busy_pre), 32'd1);
            check("vec_busy_after", 32'(busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
            check("vec_ovf", 32'(got_ovf), 32'(vecs[v].exp_ovf));
`endif
            @(negedge clk);
            check("vec_done_pulse_width", 32'(done), 32'd0);
            check("vec_d_hold", 32'(d), 32'(vecs[v].exp_d));
        end

        // ---------------- back-to-back ----------------
        issue(8'h90, 8'h30);
        wait_done(lat, got_d, got_ovf, busy_pre);
        $display("b2b first: a=0x90 b=0x30 d=0x%03h latency=%0d", got_d, lat);
        check("b2b_first_d", 32'(got_d), 32'h060);
        issue(8'h30, 8'h90);          // start in the done cycle, FSM in IDLE
        wait_done(lat, got_d, got_ovf, busy_pre);
        $display("b2b second: a=0x30 b=0x90 d=0x%03h latency=%0d", got_d, lat);
        check("b2b_second_d", 32'(got_d), 32'h1A0);
        check("b2b_second_latency", 32'(lat), 32'd9);
        @(negedge clk);

        // ---------------- start while busy is ignored ----------------
        issue(8'h50, 8'h20);
        ndone = 0;
        dval  = '0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 3) issue(8'hFF, 8'h00);
            if (i == 4) start = 1'b0;
            if (done) begin
                ndone++;
                dval = d;
            end
        end
        $display("busy-start: a=0x50 b=0x20 dones=%0d d=0x%03h", ndone, dval);
        check("busy_start_done_count", 32'(ndone), 32'd1);
        check("busy_start_result", 32'(dval), 32'h030);
        check("busy_start_d_final", 32'(d), 32'h030);

        // ---------------- EN=0 across a full operation ----------------
        EN      = 1'b0;
        drv_en  = 1'b1;
        drv_val = 9'h155;
        issue(8'h33, 8'h11);
        ndone = 0;
        bad   = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 7) drv_val = 9'h0AA;
            #1;
            if (d !== drv_val) bad++;
            if (done) ndone++;
        end
        check("en0_bus_released_cycles_bad", 32'(bad), 32'd0);
        check("en0_done_count", 32'(ndone), 32'd1);
        drv_en = 1'b0;
        EN     = 1'b1;
        #1;
        $display("en0 op: a=0x33 b=0x11 d after EN=1 is 0x%03h", d);
        check("en0_then_en1_d", 32'(d), 32'h022);

        // ---------------- reset in the middle of SHIFT ----------------
        @(negedge clk);
        issue(8'h50, 8'h20);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_d", 32'(d), 32'h000);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        $display("mid-op reset: dones after reset=%0d d=0x%03h", ndone, d);
        check("midreset_no_done", 32'(ndone), 32'd0);
        check("midreset_d_stays_zero", 32'(d), 32'h000);
        issue(8'h20, 8'h50);
        wait_done(lat, got_d, got_ovf, busy_pre);
        $display("post-reset op: a=0x20 b=0x50 d=0x%03h latency=%0d", got_d, lat);
        check("post_reset_d", 32'(got_d), 32'h1D0);
        check("post_reset_latency", 32'(lat), 32'd9);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
